// File: rtl/pixel_stream_pkg.sv
// Shared definitions for the packed 24-bit RGB video stream (packer and unpacker).
// Frame geometry defaults, byte-lane/pixel-field layout and the word-phase encoding.
package pixel_stream_pkg;

  localparam int unsigned X_SIZE_DEF     = 1280;
  localparam int unsigned Y_SIZE_DEF     = 720;
  localparam int unsigned WORDS_PER_LINE = 3 * X_SIZE_DEF / 4;

  localparam int unsigned LANE_W = 8;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned PIX_W  = 24;
  localparam int unsigned B_LSB  = 0;
  localparam int unsigned G_LSB  = 8;
  localparam int unsigned R_LSB  = 16;

  typedef logic [PIX_W-1:0] pixel_t;

  // Position of the current word within a W0/W1/W2 group; PH3 drains the fourth pixel.
  localparam logic [1:0] PH0 = 2'd0;
  localparam logic [1:0] PH1 = 2'd1;
  localparam logic [1:0] PH2 = 2'd2;
  localparam logic [1:0] PH3 = 2'd3;

  typedef struct packed {
    logic start;     // word is word 0 of line 0 (after any resync)
    logic line_end;  // word is the last one of its line
  } frame_info_t;

  function automatic int unsigned words_per_line(input int unsigned x_size);
    return 3 * x_size / 4;
  endfunction

endpackage

// File: rtl/pixel_frame_checker.sv
// Tracks word/line position of accepted words, checks tuser/tlast framing and
// keeps the frame counter (wrapping) and the two error counters (saturating).
module pixel_frame_checker
  import pixel_stream_pkg::*;
#(
  parameter int unsigned X_SIZE = X_SIZE_DEF,
  parameter int unsigned Y_SIZE = Y_SIZE_DEF
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        acc_i,
  input  logic        tuser_i,
  input  logic        tlast_i,
  output frame_info_t info_o,
  output logic [15:0] frame_count_o,
  output logic [7:0]  sof_err_count_o,
  output logic [7:0]  eol_err_count_o
);

  localparam int unsigned WordsPerLine = words_per_line(X_SIZE);
  localparam int unsigned XW = (WordsPerLine > 1) ? $clog2(WordsPerLine) : 1;
  localparam int unsigned YW = (Y_SIZE > 1) ? $clog2(Y_SIZE) : 1;

  logic [XW-1:0] x_q, x_d, x_eff;
  logic [YW-1:0] y_q, y_d, y_eff;
  logic [15:0]   frame_q, frame_d;
  logic [7:0]    sof_err_q, sof_err_d;
  logic [7:0]    eol_err_q, eol_err_d;
  logic          at_origin, at_last_word, at_last_line, line_end;

  always_comb begin
    at_origin    = (x_q == '0) && (y_q == '0);
    // tuser resyncs: the word is treated as word 0 of line 0 regardless of position.
    x_eff        = tuser_i ? '0 : x_q;
    y_eff        = tuser_i ? '0 : y_q;
    at_last_word = (x_eff == XW'(WordsPerLine - 1));
    at_last_line = (y_eff == YW'(Y_SIZE - 1));
    line_end     = tlast_i || at_last_word;

    info_o.start    = tuser_i || at_origin;
    info_o.line_end = line_end;

    x_d       = x_q;
    y_d       = y_q;
    frame_d   = frame_q;
    sof_err_d = sof_err_q;
    eol_err_d = eol_err_q;

    if (acc_i) begin
      if ((tuser_i != at_origin) && (sof_err_q != 8'hFF)) sof_err_d = sof_err_q + 8'd1;
      if ((tlast_i != at_last_word) && (eol_err_q != 8'hFF)) eol_err_d = eol_err_q + 8'd1;
      if (line_end) begin
        x_d = '0;
        if (at_last_line) begin
          y_d     = '0;
          frame_d = frame_q + 16'd1;
        end else begin
          y_d = y_eff + 1'b1;
        end
      end else begin
        x_d = x_eff + 1'b1;
        y_d = y_eff;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      x_q       <= '0;
      y_q       <= '0;
      frame_q   <= '0;
      sof_err_q <= '0;
      eol_err_q <= '0;
    end else begin
      x_q       <= x_d;
      y_q       <= y_d;
      frame_q   <= frame_d;
      sof_err_q <= sof_err_d;
      eol_err_q <= eol_err_d;
    end
  end

  assign frame_count_o   = frame_q;
  assign sof_err_count_o = sof_err_q;
  assign eol_err_count_o = eol_err_q;

endmodule

// File: rtl/pixel_unpacker.sv
// Sink for the packed 24-bit RGB stream: turns each group of three 32-bit words into
// four pixels presented one per handshake on a registered valid/ready output.
module pixel_unpacker
  import pixel_stream_pkg::*;
#(
  parameter int unsigned X_SIZE = X_SIZE_DEF,
  parameter int unsigned Y_SIZE = Y_SIZE_DEF
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [WORD_W-1:0] in_stream_tdata,
  input  logic [3:0]        in_stream_tkeep,
  input  logic              in_stream_tlast,
  input  logic              in_stream_tuser,
  input  logic              in_stream_tvalid,
  output logic              in_stream_tready,
  output logic [7:0]        r,
  output logic [7:0]        g,
  output logic [7:0]        b,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_sof,
  output logic              pix_eol,
  output logic [15:0]       frame_count,
  output logic [7:0]        sof_err_count,
  output logic [7:0]        eol_err_count
);

  logic [1:0]  phase_q, phase_d, phase_eff;
  pixel_t      held_q, held_d, pix_q, pix_d;
  logic        valid_q, valid_d, sof_q, sof_d, eol_q, eol_d, eol_pend_q, eol_pend_d;
  logic        out_adv, word_acc;
  frame_info_t info;

  // tkeep carries no information on this stream.
  logic unused_tkeep;
  assign unused_tkeep = ^in_stream_tkeep;

  assign out_adv          = !valid_q || pix_ready;
  assign in_stream_tready = aresetn && (phase_q != PH3) && out_adv;
  assign word_acc         = in_stream_tvalid && in_stream_tready;

  pixel_frame_checker #(
    .X_SIZE (X_SIZE),
    .Y_SIZE (Y_SIZE)
  ) u_checker (
    .clk_i           (aclk),
    .rst_ni          (aresetn),
    .acc_i           (word_acc),
    .tuser_i         (in_stream_tuser),
    .tlast_i         (in_stream_tlast),
    .info_o          (info),
    .frame_count_o   (frame_count),
    .sof_err_count_o (sof_err_count),
    .eol_err_count_o (eol_err_count)
  );

  always_comb begin
    phase_eff  = info.start ? PH0 : phase_q;
    phase_d    = phase_q;
    held_d     = held_q;
    pix_d      = pix_q;
    valid_d    = valid_q;
    sof_d      = sof_q;
    eol_d      = eol_q;
    eol_pend_d = eol_pend_q;

    if (out_adv) valid_d = 1'b0;

    if (word_acc) begin
      valid_d    = 1'b1;
      sof_d      = info.start;
      // A line ending on W2 still owes P3, which then carries the end-of-line mark.
      eol_d      = info.line_end && (phase_eff != PH2);
      eol_pend_d = info.line_end;
      case (phase_eff)
        PH0: begin
          pix_d  = in_stream_tdata[23:0];
          held_d = {16'h0000, in_stream_tdata[31:24]};
        end
        PH1: begin
          pix_d  = {in_stream_tdata[15:0], held_q[7:0]};
          held_d = {8'h00, in_stream_tdata[31:16]};
        end
        default: begin
          pix_d  = {in_stream_tdata[7:0], held_q[15:0]};
          held_d = in_stream_tdata[31:8];
        end
      endcase
      if (info.line_end && (phase_eff != PH2)) phase_d = PH0;
      else                                     phase_d = phase_eff + 2'd1;
    end else if ((phase_q == PH3) && out_adv) begin
      valid_d = 1'b1;
      pix_d   = held_q;
      sof_d   = 1'b0;
      eol_d   = eol_pend_q;
      phase_d = PH0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      phase_q    <= PH0;
      held_q     <= '0;
      pix_q      <= '0;
      valid_q    <= 1'b0;
      sof_q      <= 1'b0;
      eol_q      <= 1'b0;
      eol_pend_q <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      held_q     <= held_d;
      pix_q      <= pix_d;
      valid_q    <= valid_d;
      sof_q      <= sof_d;
      eol_q      <= eol_d;
      eol_pend_q <= eol_pend_d;
    end
  end

  assign r         = pix_q[R_LSB +: LANE_W];
  assign g         = pix_q[G_LSB +: LANE_W];
  assign b         = pix_q[B_LSB +: LANE_W];
  assign pix_valid = valid_q;
  assign pix_sof   = sof_q;
  assign pix_eol   = eol_q;

endmodule
